// File: rtl/exc_int_ctrl.sv
// Parametrised exception/interrupt controller: per-source edge/level pending
// capture, maskable fixed-priority request, EPC save and RFE return handshake.
module exc_int_ctrl #(
  parameter int unsigned          NUM_SRC   = 4,
  parameter int unsigned          PC_W      = 32,
  parameter int unsigned          ID_W      = 2,
  parameter logic [NUM_SRC-1:0]   EDGE_MASK = 4'b1000,
  parameter logic [NUM_SRC-1:0]   MASK_RST  = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic [PC_W-1:0]    pc_in,
  input  logic               int_ack,
  input  logic               rfe,
  output logic               int_req,
  output logic [ID_W-1:0]    cause_id,
  output logic [PC_W-1:0]    epc,
  output logic               epc_sel,
  output logic               in_handler,
  output logic [NUM_SRC-1:0] pending
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERVICE,
    ST_RETURN
  } state_t;

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] src_set;
  logic [NUM_SRC-1:0] src_clr;
  logic [NUM_SRC-1:0] eff;
  logic [ID_W-1:0]    winner;
  logic               any_eff;
  logic               accept;
  logic               start_req;

  assign eff       = pending & mask;
  assign any_eff   = |eff;
  assign accept    = (state == ST_REQ) && int_ack;
  assign start_req = (state == ST_IDLE) && any_eff;

  // Edge sources set on a 0->1 transition, level sources on any high cycle.
  assign src_set = (EDGE_MASK & src & ~src_q) | (~EDGE_MASK & src);

  always_comb begin
    winner = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (eff[i-1]) winner = ID_W'(i - 1);
    end
  end

  always_comb begin
    src_clr = '0;
    if (accept) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (cause_id == ID_W'(i)) src_clr[i] = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (any_eff) state_nxt = ST_REQ;
      ST_REQ:     if (int_ack) state_nxt = ST_SERVICE;
      ST_SERVICE: if (rfe)     state_nxt = ST_RETURN;
      ST_RETURN:               state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    int_req    = 1'b0;
    in_handler = 1'b0;
    epc_sel    = 1'b0;
    unique case (state)
      ST_REQ:     int_req    = 1'b1;
      ST_SERVICE: in_handler = 1'b1;
      ST_RETURN:  epc_sel    = 1'b1;
      default: ;
    endcase
  end

  // Set is ORed after the clear so a same-cycle re-trigger keeps the bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending <= '0;
      src_q   <= '0;
      mask    <= MASK_RST;
    end else begin
      pending <= (pending & ~src_clr) | src_set;
      src_q   <= src;
      if (mask_we) mask <= mask_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cause_id <= '0;
      epc      <= '0;
    end else begin
      if (start_req) cause_id <= winner;
      if (accept)    epc      <= pc_in;
    end
  end

endmodule

// File: tb/tb_exc_int_ctrl.sv
// Self-checking bench for exc_int_ctrl: directed vector table, hand-written
// corner sequences and randomized stimulus against a behavioural model.
module tb_exc_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  src;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic [31:0] pc_in;
  logic        int_ack;
  logic        rfe;
  logic        int_req;
  logic [1:0]  cause_id;
  logic [31:0] epc;
  logic        epc_sel;
  logic        in_handler;
  logic [3:0]  pending;

  localparam logic [3:0] EDGE = 4'b1000;

  exc_int_ctrl #(
    .NUM_SRC   (4),
    .PC_W      (32),
    .ID_W      (2),
    .EDGE_MASK (4'b1000),
    .MASK_RST  (4'b1111)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .src        (src),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .pc_in      (pc_in),
    .int_ack    (int_ack),
    .rfe        (rfe),
    .int_req    (int_req),
    .cause_id   (cause_id),
    .epc        (epc),
    .epc_sel    (epc_sel),
    .in_handler (in_handler),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: the controller is either idle, requesting, in a
  // handler, or returning; tracked as three flags (none set = idle).
  logic [3:0]  m_pend = '0, m_mask = '1, m_prev = '0;
  logic [31:0] m_epc = '0;
  logic [1:0]  m_cause = '0;
  logic        m_req = 1'b0, m_svc = 1'b0, m_ret = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [1:0] lowest(input logic [3:0] v);
    logic [1:0] r = '0;
    for (int i = 3; i >= 0; i--) if (v[i]) r = 2'(i);
    return r;
  endfunction

  task automatic model_edge();
    logic [3:0] newly, eff;
    if (!reset) begin
      m_pend = '0; m_mask = '1; m_prev = '0; m_epc = '0; m_cause = '0;
      m_req = 1'b0; m_svc = 1'b0; m_ret = 1'b0;
      return;
    end
    eff = m_pend & m_mask;
    for (int i = 0; i < 4; i++)
      newly[i] = EDGE[i] ? (src[i] && !m_prev[i]) : src[i];
    if (m_ret) begin
      m_ret = 1'b0;
    end else if (m_svc) begin
      if (rfe) begin m_svc = 1'b0; m_ret = 1'b1; end
    end else if (m_req) begin
      if (int_ack) begin
        m_req = 1'b0; m_svc = 1'b1; m_epc = pc_in;
        m_pend[m_cause] = 1'b0;
      end
    end else if (eff != 0) begin
      m_req = 1'b1; m_cause = lowest(eff);
    end
    m_pend = m_pend | newly;
    if (mask_we) m_mask = mask_wdata;
    m_prev = src;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cmp_model();
    chk("int_req",    32'(int_req),    32'(m_req));
    chk("in_handler", 32'(in_handler), 32'(m_svc));
    chk("epc_sel",    32'(epc_sel),    32'(m_ret));
    chk("cause_id",   32'(cause_id),   32'(m_cause));
    chk("epc",        epc,             m_epc);
    chk("pending",    32'(pending),    32'(m_pend));
  endtask

  task automatic idle_inputs();
    reset = 1'b1; src = '0; mask_we = 1'b0; mask_wdata = '0;
    pc_in = '0; int_ack = 1'b0; rfe = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  src;
    logic [31:0] pc;
    logic        ack;
    logic        rfe;
    logic        req;
    logic [1:0]  cause;
    logic [31:0] epc;
    logic        sel;
    logic        inh;
    logic [3:0]  pend;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [3:0] s, logic [31:0] pc, logic a, logic r,
                              logic req, logic [1:0] c, logic [31:0] e, logic sel,
                              logic inh, logic [3:0] p);
    vec_t v;
    v.rst = rst; v.src = s; v.pc = pc; v.ack = a; v.rfe = r;
    v.req = req; v.cause = c; v.epc = e; v.sel = sel; v.inh = inh; v.pend = p;
    return v;
  endfunction

  vec_t tbl[29];
  int   services;

  initial begin
    //                rst src   pc      ack rfe  req cause epc     sel inh pend
    tbl[0]  = mk(1'b0, 4'hF, 32'h0,   0, 0,   0, 2'd0, 32'h0,   0, 0, 4'h0);
    tbl[1]  = mk(1'b0, 4'hF, 32'h0,   0, 0,   0, 2'd0, 32'h0,   0, 0, 4'h0);
    tbl[2]  = mk(1'b1, 4'hF, 32'h0,   0, 0,   0, 2'd0, 32'h0,   0, 0, 4'hF);
    tbl[3]  = mk(1'b1, 4'h0, 32'h0,   0, 0,   1, 2'd0, 32'h0,   0, 0, 4'hF);
    tbl[4]  = mk(1'b1, 4'h0, 32'h100, 1, 0,   0, 2'd0, 32'h100, 0, 1, 4'hE);
    tbl[5]  = mk(1'b1, 4'h0, 32'h0,   0, 1,   0, 2'd0, 32'h100, 1, 0, 4'hE);
    tbl[6]  = mk(1'b1, 4'h0, 32'h0,   0, 0,   0, 2'd0, 32'h100, 0, 0, 4'hE);
    tbl[7]  = mk(1'b1, 4'h0, 32'h0,   0, 0,   1, 2'd1, 32'h100, 0, 0, 4'hE);
    tbl[8]  = mk(1'b1, 4'h0, 32'h40,  1, 0,   0, 2'd1, 32'h40,  0, 1, 4'hC);
    tbl[9]  = mk(1'b1, 4'h0, 32'h0,   0, 0,   0, 2'd1, 32'h40,  0, 1, 4'hC);
    tbl[10] = mk(1'b1, 4'h0, 32'h0,   0, 1,   0, 2'd1, 32'h40,  1, 0, 4'hC);
    tbl[11] = mk(1'b1, 4'h0, 32'h0,   0, 0,   0, 2'd1, 32'h40,  0, 0, 4'hC);
    tbl[12] = mk(1'b1, 4'h0, 32'h0,   0, 0,   1, 2'd2, 32'h40,  0, 0, 4'hC);
    tbl[13] = mk(1'b1, 4'h0, 32'h80,  1, 0,   0, 2'd2, 32'h80,  0, 1, 4'h8);
    tbl[14] = mk(1'b1, 4'h0, 32'h0,   0, 1,   0, 2'd2, 32'h80,  1, 0, 4'h8);
    tbl[15] = mk(1'b1, 4'h0, 32'h0,   0, 0,   0, 2'd2, 32'h80,  0, 0, 4'h8);
    tbl[16] = mk(1'b1, 4'h0, 32'h0,   0, 0,   1, 2'd3, 32'h80,  0, 0, 4'h8);
    tbl[17] = mk(1'b1, 4'h0, 32'hC0,  1, 0,   0, 2'd3, 32'hC0,  0, 1, 4'h0);
    tbl[18] = mk(1'b1, 4'h0, 32'h0,   0, 1,   0, 2'd3, 32'hC0,  1, 0, 4'h0);
    tbl[19] = mk(1'b1, 4'h0, 32'h0,   0, 1,   0, 2'd3, 32'hC0,  0, 0, 4'h0);
    tbl[20] = mk(1'b1, 4'h0, 32'h0,   0, 1,   0, 2'd3, 32'hC0,  0, 0, 4'h0);
    tbl[21] = mk(1'b1, 4'hA, 32'h0,   0, 0,   0, 2'd3, 32'hC0,  0, 0, 4'hA);
    tbl[22] = mk(1'b1, 4'h1, 32'h0,   0, 0,   1, 2'd1, 32'hC0,  0, 0, 4'hB);
    tbl[23] = mk(1'b1, 4'h0, 32'h0,   0, 0,   1, 2'd1, 32'hC0,  0, 0, 4'hB);
    tbl[24] = mk(1'b1, 4'h0, 32'h200, 1, 0,   0, 2'd1, 32'h200, 0, 1, 4'h9);
    tbl[25] = mk(1'b1, 4'h0, 32'h0,   0, 1,   0, 2'd1, 32'h200, 1, 0, 4'h9);
    tbl[26] = mk(1'b1, 4'h0, 32'h0,   0, 0,   0, 2'd1, 32'h200, 0, 0, 4'h9);
    tbl[27] = mk(1'b1, 4'h0, 32'h0,   0, 0,   1, 2'd0, 32'h200, 0, 0, 4'h9);
    tbl[28] = mk(1'b1, 4'h0, 32'h300, 1, 0,   0, 2'd0, 32'h300, 0, 1, 4'h8);

    idle_inputs();
    for (int i = 0; i < 29; i++) begin
      reset = tbl[i].rst; src = tbl[i].src; pc_in = tbl[i].pc;
      int_ack = tbl[i].ack; rfe = tbl[i].rfe;
      step();
      chk($sformatf("tbl%0d.int_req", i),    32'(int_req),    32'(tbl[i].req));
      chk($sformatf("tbl%0d.cause_id", i),   32'(cause_id),   32'(tbl[i].cause));
      chk($sformatf("tbl%0d.epc", i),        epc,             tbl[i].epc);
      chk($sformatf("tbl%0d.epc_sel", i),    32'(epc_sel),    32'(tbl[i].sel));
      chk($sformatf("tbl%0d.in_handler", i), 32'(in_handler), 32'(tbl[i].inh));
      chk($sformatf("tbl%0d.pending", i),    32'(pending),    32'(tbl[i].pend));
    end

    // Mask: masked edge source is recorded but not requested.
    idle_inputs(); reset = 1'b0; step(); step(); cmp_model();
    reset = 1'b1; mask_we = 1'b1; mask_wdata = 4'b0111; step(); cmp_model();
    mask_we = 1'b0; src = 4'b1000; step(); cmp_model();
    src = '0;
    for (int i = 0; i < 4; i++) begin step(); cmp_model(); end
    chk("mask.int_req_blocked", 32'(int_req), 32'd0);
    chk("mask.pending3", 32'(pending[3]), 32'd1);
    mask_we = 1'b1; mask_wdata = 4'b1111; step(); cmp_model();
    mask_we = 1'b0; step(); cmp_model();
    chk("mask.int_req_after", 32'(int_req), 32'd1);
    chk("mask.cause", 32'(cause_id), 32'd3);
    int_ack = 1'b1; pc_in = 32'h1234; step(); cmp_model();
    int_ack = 1'b0; rfe = 1'b1; step(); cmp_model();
    rfe = 1'b0; step(); cmp_model(); step(); cmp_model();

    // Edge source held high across the ack: exactly one service.
    services = 0;
    src = 4'b1000;
    for (int i = 0; i < 16; i++) begin
      if (i >= 10) src = '0;
      int_ack = m_req; rfe = m_svc;
      if (m_req) services++;
      step(); cmp_model();
    end
    chk("edge_held.services", 32'(services), 32'd1);

    // Level source held high: re-pends after ack, requests again after RETURN.
    services = 0;
    src = 4'b0010; int_ack = 1'b0; rfe = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i >= 10) src = '0;
      int_ack = m_req; rfe = m_svc;
      if (m_req) services++;
      step(); cmp_model();
    end
    chk("level_held.multi", 32'(services >= 2), 32'd1);
    int_ack = 1'b0; rfe = 1'b0;
    for (int i = 0; i < 8; i++) begin
      int_ack = m_req; rfe = m_svc; step(); cmp_model();
    end

    // Stray rfe in IDLE, then reset while in SERVICE.
    int_ack = 1'b0; rfe = 1'b1; step(); cmp_model();
    chk("stray_rfe.epc_sel", 32'(epc_sel), 32'd0);
    rfe = 1'b0; src = 4'b0100; step(); cmp_model();
    src = '0; step(); cmp_model();
    int_ack = 1'b1; pc_in = 32'hBEEF; step(); cmp_model();
    int_ack = 1'b0; chk("svc.in_handler", 32'(in_handler), 32'd1);
    src = 4'b0001; reset = 1'b0; step(); cmp_model();
    chk("midreset.in_handler", 32'(in_handler), 32'd0);
    chk("midreset.pending", 32'(pending), 32'd0);
    chk("midreset.epc", epc, 32'd0);
    reset = 1'b1; src = '0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      src        = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      int_ack    = ($urandom_range(0, 3) != 0);
      rfe        = ($urandom_range(0, 2) == 0);
      mask_we    = ($urandom_range(0, 19) == 0);
      mask_wdata = 4'($urandom_range(0, 15));
      pc_in      = $urandom;
      reset      = ($urandom_range(0, 99) != 0);
      step(); cmp_model();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exc_int_ctrl.md
Name: exc_int_ctrl

Overview:
- Parametrised exception/interrupt controller for the single-cycle MIPS core; generalises the four fixed latches, priority encoder, OR gate, EPC and done register into one block.
- Supports N sources, per-source edge/level mode, a writable mask and a request/ack/return handshake with the controller.
- Sits in the datapath between the raw exception sources (syscall, overflow, invalid, ext_int, …) and the PC-select logic.

Parameters:
- NUM_SRC, 4, number of exception sources (1..16); index 0 has highest priority.
- PC_W, 32, width of PC and EPC.
- ID_W, 2, width of the cause ID; must satisfy 2**ID_W >= NUM_SRC.
- EDGE_MASK, 4'b1000, bit i = 1: source i is rising-edge sensitive; bit i = 0: source i is level sensitive.
- MASK_RST, all ones, mask value after reset (1 = enabled).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous reset, active-low.
- src  in  NUM_SRC  raw exception/interrupt inputs.
- mask_we  in  1  load mask_wdata into the mask register.
- mask_wdata  in  NUM_SRC  new mask value.
- pc_in  in  PC_W  PC to save; the core drives pcnext.
- int_ack  in  1  core has redirected to the handler.
- rfe  in  1  core is executing RFE.
- int_req  out  1  request to redirect to the handler.
- cause_id  out  ID_W  ID of the source being serviced.
- epc  out  PC_W  saved return address.
- epc_sel  out  1  one-cycle pulse: the core must take epc as the next PC.
- in_handler  out  1  high while a handler is active.
- pending  out  NUM_SRC  raw pending bits, before masking.

Behaviour:
- Reset (reset = 0 at a clock edge):
  - pending = 0, mask = MASK_RST, epc = 0, cause_id = 0.
  - State = IDLE; int_req, epc_sel and in_handler = 0.
  - Edge-detect history = 0.
  - Reset wins over every other input in the same cycle, including mid-handler.
- Pending set:
  - Edge sources: set when src[i] = 1 and the previous-cycle src[i] = 0.
  - Level sources: set on any cycle with src[i] = 1.
  - Pending is sticky until cleared.
- Pending clear:
  - Only the accepted source's bit is cleared, on the int_ack cycle.
  - If the same source's set condition is true in that same cycle, set wins; the bit stays 1.
- Mask:
  - Applied only to request generation; pending still records masked sources.
  - On mask_we, the mask updates next edge and the new value is used from the following cycle.
- eff = pending & mask; winner = lowest index set in eff.
- State machine:
  - IDLE: int_req = 0. If eff != 0, go to REQ and latch cause_id = winner.
  - REQ: int_req = 1; cause_id holds (a newly arriving higher-priority source does not preempt). On int_ack: epc <= pc_in, clear pending[cause_id], go to SERVICE.
  - SERVICE: in_handler = 1, int_req = 0, no nesting; new sources only latch. On rfe, go to RETURN.
  - RETURN: epc_sel = 1 for exactly this cycle, then go to IDLE. If eff != 0 in RETURN, IDLE re-requests next cycle, so there is at least one cycle with epc_sel before a new int_req.
- Ignored inputs:
  - rfe in IDLE or REQ is ignored (no epc_sel).
  - int_ack outside REQ is ignored.
- Latency:
  - Source edge to int_req high is 2 cycles: pending registered, then REQ.
  - int_ack to in_handler is 1 cycle.
  - rfe to epc_sel is 1 cycle.
- epc holds its value until the next accepted int_ack. cause_id holds until the next IDLE→REQ transition.
- Widths: cause_id is zero-extended from the winner index; the NUM_SRC < 2**ID_W upper codes are unused.

Test Plan:
- Reset: hold reset = 0 for 2 cycles with src = 4'b1111 → pending = 0, int_req = 0, epc = 0. Release → pending = 4'b1111 next cycle, int_req = 1 the cycle after, cause_id = 0.
- Single level source: src[2] = 1 for 1 cycle, pc_in = 32'h0000_0040, int_ack one cycle after int_req, rfe 3 cycles later → epc = 32'h40, cause_id = 2, in_handler high 4 cycles, epc_sel single pulse, pending = 0.
- Priority and no preemption: src = 4'b1010 simultaneously → cause_id = 1. Raise src[0] during REQ → cause_id stays 1. After RETURN, next request has cause_id = 0, then cause_id = 3 after it.
- Mask: write mask = 4'b0111, pulse src[3] (edge) → pending[3] = 1, int_req stays 0. Write mask = 4'b1111 → int_req 2 cycles later, cause_id = 3.
- Edge source held high: src[3] = 1 for 10 cycles across ack → exactly one service. Same with src[1] (level) held high → re-pending after ack, second request follows RETURN.
- Stray and mid-operation events: rfe in IDLE → no epc_sel. reset = 0 while in SERVICE → in_handler = 0 and pending = 0 next cycle, epc = 0.
